// File: rtl/ds1302_ctrlmod_pkg.sv
// rtl/ds1302_ctrlmod_pkg.sv - DS1302 command bytes, bit masks and sequencer state encodings
package ds1302_ctrlmod_pkg;

  localparam logic [7:0] CMD_WP     = 8'h8E;
  localparam logic [7:0] CMD_WR_SEC = 8'h80;
  localparam logic [7:0] CMD_RD_SEC = 8'h81;
  localparam logic [7:0] CMD_WR_MIN = 8'h82;
  localparam logic [7:0] CMD_RD_MIN = 8'h83;
  localparam logic [7:0] CMD_WR_HR  = 8'h84;
  localparam logic [7:0] CMD_RD_HR  = 8'h85;

  localparam logic [7:0] CH_MASK      = 8'h80;
  localparam logic [7:0] HR_1224_MASK = 8'h80;
  localparam logic [7:0] SEC_RD_MASK  = 8'h7F;
  localparam logic [7:0] MIN_RD_MASK  = 8'h7F;
  localparam logic [7:0] HR_RD_MASK   = 8'h3F;

  localparam logic [1:0] CALL_IDLE = 2'b00;
  localparam logic [1:0] CALL_RD   = 2'b01;
  localparam logic [1:0] CALL_WR   = 2'b10;

  typedef enum logic [3:0] {
    INIT_WP, INIT_H, INIT_M, INIT_S,
    LOOP, RD_S, RD_M, RD_H, PUBLISH, WAIT,
    SET_WP, SET_H, SET_M, SET_S
  } state_t;

  typedef struct packed {
    logic       txn;
    logic [1:0] call;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

endpackage

// File: rtl/ds1302_ctrlmod.sv
// rtl/ds1302_ctrlmod.sv - DS1302 init/poll/set command sequencer driving ds1302_funcmod
module ds1302_ctrlmod
  import ds1302_ctrlmod_pkg::*;
#(
  parameter int          POLL_CYCLES = 2_500_000,
  parameter logic [23:0] INIT_TIME   = 24'h12_00_00
) (
  input  logic        CLOCK,
  input  logic        RESET,
  output logic [1:0]  oCall,
  input  logic        iDone,
  output logic [7:0]  oAddr,
  output logic [7:0]  oData,
  input  logic [7:0]  iData,
  input  logic        iSet,
  input  logic [23:0] iSetTime,
  output logic [23:0] oTime,
  output logic        oTimeValid,
  output logic        oSetAck
);

  state_t      state, state_d;
  cmd_t        cmd;
  logic [1:0]  call_q, call_d;
  logic [7:0]  addr_q, addr_d, data_q, data_d;
  logic [7:0]  sec_q, sec_d, min_q, min_d;
  logic [23:0] time_q, time_d;
  logic        tv_q, tv_d, ack_q, ack_d;
  logic        pend_q, pend_d;
  logic [23:0] pend_time_q, pend_time_d, set_time_q, set_time_d;
  logic [31:0] cnt_q, cnt_d;
  logic [23:0] src_time;
  logic        set_phase, done;

  assign set_phase = (state == SET_WP) || (state == SET_H) || (state == SET_M) || (state == SET_S);
  assign src_time  = set_phase ? set_time_q : INIT_TIME;

  // Per-state transaction descriptor; CH and 12/24 bits are forced low on writes.
  always_comb begin
    cmd = '{txn: 1'b0, call: CALL_IDLE, addr: 8'h00, data: 8'h00};
    case (state)
      INIT_WP, SET_WP: cmd = '{1'b1, CALL_WR, CMD_WP, 8'h00};
      INIT_H, SET_H:   cmd = '{1'b1, CALL_WR, CMD_WR_HR, src_time[23:16] & ~HR_1224_MASK};
      INIT_M, SET_M:   cmd = '{1'b1, CALL_WR, CMD_WR_MIN, src_time[15:8]};
      INIT_S, SET_S:   cmd = '{1'b1, CALL_WR, CMD_WR_SEC, src_time[7:0] & ~CH_MASK};
      RD_S:            cmd = '{1'b1, CALL_RD, CMD_RD_SEC, 8'h00};
      RD_M:            cmd = '{1'b1, CALL_RD, CMD_RD_MIN, 8'h00};
      RD_H:            cmd = '{1'b1, CALL_RD, CMD_RD_HR, 8'h00};
      default: ;
    endcase
  end

  // A done pulse only counts while our call is actually asserted.
  assign done = cmd.txn && (call_q != CALL_IDLE) && iDone;

  always_comb begin
    state_d     = state;
    call_d      = call_q;
    addr_d      = addr_q;
    data_d      = data_q;
    sec_d       = sec_q;
    min_d       = min_q;
    time_d      = time_q;
    tv_d        = 1'b0;
    ack_d       = 1'b0;
    pend_d      = pend_q;
    pend_time_d = pend_time_q;
    set_time_d  = set_time_q;
    cnt_d       = cnt_q;

    if (iSet) begin
      pend_d      = 1'b1;
      pend_time_d = iSetTime;
    end

    if (cmd.txn) begin
      if (done) begin
        call_d = CALL_IDLE;
        case (state)
          INIT_WP: state_d = INIT_H;
          INIT_H:  state_d = INIT_M;
          INIT_M:  state_d = INIT_S;
          INIT_S:  state_d = LOOP;
          RD_S: begin
            sec_d   = iData & SEC_RD_MASK;
            state_d = RD_M;
          end
          RD_M: begin
            min_d   = iData & MIN_RD_MASK;
            state_d = RD_H;
          end
          RD_H: begin
            time_d  = {iData & HR_RD_MASK, min_q, sec_q};
            tv_d    = 1'b1;
            state_d = PUBLISH;
          end
          SET_WP:  state_d = SET_H;
          SET_H:   state_d = SET_M;
          SET_M:   state_d = SET_S;
          SET_S: begin
            ack_d   = 1'b1;
            state_d = LOOP;
          end
          default: ;
        endcase
      end else begin
        call_d = cmd.call;
        addr_d = cmd.addr;
        data_d = cmd.data;
      end
    end else begin
      case (state)
        LOOP: begin
          if (pend_q || iSet) begin
            set_time_d = iSet ? iSetTime : pend_time_q;
            pend_d     = 1'b0;
            state_d    = SET_WP;
          end else begin
            state_d = RD_S;
          end
        end
        PUBLISH: state_d = WAIT;
        WAIT: begin
          if (cnt_q == 32'(POLL_CYCLES - 1)) begin
            cnt_d   = 32'd0;
            state_d = LOOP;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state       <= INIT_WP;
      call_q      <= CALL_IDLE;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      time_q      <= 24'h0;
      tv_q        <= 1'b0;
      ack_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_time_q <= 24'h0;
      set_time_q  <= 24'h0;
      cnt_q       <= 32'd0;
    end else begin
      state       <= state_d;
      call_q      <= call_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      time_q      <= time_d;
      tv_q        <= tv_d;
      ack_q       <= ack_d;
      pend_q      <= pend_d;
      pend_time_q <= pend_time_d;
      set_time_q  <= set_time_d;
      cnt_q       <= cnt_d;
    end
  end

  assign oCall      = call_q;
  assign oAddr      = addr_q;
  assign oData      = data_q;
  assign oTime      = time_q;
  assign oTimeValid = tv_q;
  assign oSetAck    = ack_q;

endmodule

// File: tb/tb_ds1302_ctrlmod.sv
// tb/tb_ds1302_ctrlmod.sv - scoreboard bench for ds1302_ctrlmod with a fixed-latency funcmod stub
module tb_ds1302_ctrlmod;

  localparam int POLL = 200;
  localparam int LAT  = 400;

  typedef struct {
    logic [1:0] call;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  oCall;
  logic        iDone;
  logic [7:0]  oAddr, oData, iData;
  logic        iSet = 1'b0;
  logic [23:0] iSetTime = 24'h0;
  logic [23:0] oTime;
  logic        oTimeValid, oSetAck;

  txn_t        exp_q[$];
  logic [7:0]  rsp_q[$];
  logic [23:0] time_q[$];
  int          ack_exp = 0;
  int          total = 0, bad = 0;
  int          tv_count = 0, ack_count = 0;
  logic [1:0]  prev_call = 2'b00;
  logic        prev_tv = 1'b0;
  logic        stub_busy = 1'b0;
  logic [7:0]  cur_addr = 8'h00, last_addr = 8'h00;

  ds1302_ctrlmod #(.POLL_CYCLES(POLL), .INIT_TIME(24'h12_00_00)) dut (
    .CLOCK(clk), .RESET(rst_n), .oCall(oCall), .iDone(iDone), .oAddr(oAddr),
    .oData(oData), .iData(iData), .iSet(iSet), .iSetTime(iSetTime),
    .oTime(oTime), .oTimeValid(oTimeValid), .oSetAck(oSetAck)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_w(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back('{call: 2'b10, addr: a, data: d});
  endtask

  task automatic push_r(input logic [7:0] a, input logic [7:0] rsp);
    exp_q.push_back('{call: 2'b01, addr: a, data: 8'h00});
    rsp_q.push_back(rsp);
  endtask

  task automatic push_init();
    push_w(8'h8E, 8'h00); push_w(8'h84, 8'h12); push_w(8'h82, 8'h00); push_w(8'h80, 8'h00);
  endtask

  task automatic wait_tv(input int n);
    int c = 0;
    while (tv_count < n && c < 30000) begin
      @(negedge clk);
      c++;
    end
    check("tv_wait", 32'(tv_count >= n), 32'd1);
  endtask

  task automatic pulse_set(input logic [23:0] t);
    @(negedge clk);
    iSet = 1'b1;
    iSetTime = t;
    @(negedge clk);
    iSet = 1'b0;
  endtask

  // funcmod stub: answers each call with iDone after LAT cycles
  initial begin
    txn_t t;
    logic [1:0] rw;
    logic [7:0] a, d;
    bit aborted;
    iDone = 1'b0;
    iData = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && oCall != 2'b00) begin
        check("gap", 32'(prev_call), 32'd0);
        check("call_legal", 32'(oCall == 2'b11), 32'd0);
        rw = oCall; a = oAddr; d = oData;
        cur_addr = a;
        stub_busy = 1'b1;
        if (exp_q.size() == 0) begin
          check("txn_unexp", {22'h0, rw, a}, 32'd0);
        end else begin
          t = exp_q.pop_front();
          check("txn_cmd", {22'h0, rw, a}, {22'h0, t.call, t.addr});
          if (t.call == 2'b10) check("txn_data", 32'(d), 32'(t.data));
        end
        aborted = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          check("txn_hold", {14'h0, oCall, oAddr, oData}, {14'h0, rw, a, d});
          iDone = 1'b1;
          iData = (rw == 2'b01 && rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00;
          last_addr = a;
          @(negedge clk);
          iDone = 1'b0;
        end
        stub_busy = 1'b0;
      end
      prev_call = oCall;
    end
  end

  always @(negedge clk) begin
    if (oTimeValid) begin
      check("tv_single", 32'(prev_tv), 32'd0);
      check("tv_after_rd_h", 32'(last_addr), 32'h85);
      if (time_q.size() > 0) check("time", 32'(oTime), 32'(time_q.pop_front()));
      else check("time_unexp", 32'(oTime), 32'hFFFF_FFFF);
      tv_count++;
    end
    if (oSetAck) begin
      check("ack_after_set_s", 32'(last_addr), 32'h80);
      check("ack_expected", 32'(ack_exp > 0), 32'd1);
      if (ack_exp > 0) ack_exp--;
      ack_count++;
    end
    prev_tv = oTimeValid;
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    check("rst_call", 32'(oCall), 32'd0);
    check("rst_addr", 32'(oAddr), 32'd0);
    check("rst_data", 32'(oData), 32'd0);
    check("rst_time", 32'(oTime), 32'd0);
    check("rst_tv", 32'(oTimeValid), 32'd0);
    check("rst_ack", 32'(oSetAck), 32'd0);

    push_init();
    push_r(8'h81, 8'hA5); push_r(8'h83, 8'h59); push_r(8'h85, 8'hD3);
    time_q.push_back(24'h13_59_25);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_call", 32'(oCall), 32'd2);
    wait_tv(1);

    // set during WAIT, CH bit in seconds must be cleared
    repeat (5) @(negedge clk);
    push_w(8'h8E, 8'h00); push_w(8'h84, 8'h23); push_w(8'h82, 8'h45); push_w(8'h80, 8'h47);
    ack_exp++;
    push_r(8'h81, 8'h10); push_r(8'h83, 8'h20); push_r(8'h85, 8'h08);
    time_q.push_back(24'h08_20_10);
    pulse_set(24'h23_45_C7);
    wait_tv(2);

    // two sets in one round: newest wins, single sequence
    repeat (5) @(negedge clk);
    push_w(8'h8E, 8'h00); push_w(8'h84, 8'h04); push_w(8'h82, 8'h05); push_w(8'h80, 8'h06);
    ack_exp++;
    push_r(8'h81, 8'hD9); push_r(8'h83, 8'h59); push_r(8'h85, 8'h92);
    time_q.push_back(24'h12_59_59);
    push_r(8'h81, 8'h01); push_r(8'h83, 8'h02);
    pulse_set(24'h01_02_03);
    repeat (3) @(negedge clk);
    pulse_set(24'h04_05_06);
    wait_tv(3);

    // reset asserted in the middle of RD_M
    c = 0;
    while (!(stub_busy && cur_addr == 8'h83) && c < 30000) begin
      @(negedge clk);
      c++;
    end
    check("reach_rd_m", 32'(stub_busy && cur_addr == 8'h83), 32'd1);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_call", 32'(oCall), 32'd0);
    check("midrst_time", 32'(oTime), 32'd0);
    check("midrst_addr", 32'(oAddr), 32'd0);
    rsp_q.delete();
    exp_q.delete();
    push_init();
    push_r(8'h81, 8'h07); push_r(8'h83, 8'h08); push_r(8'h85, 8'h09);
    time_q.push_back(24'h09_08_07);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("restart_call", 32'(oCall), 32'd2);
    check("restart_addr", 32'(oAddr), 32'h8E);
    wait_tv(4);

    repeat (5) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("time_q_drained", 32'(time_q.size()), 32'd0);
    check("ack_count", 32'(ack_count), 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ds1302_ctrlmod.md
# ds1302_ctrlmod

Command sequencer that sits directly upstream of `ds1302_funcmod` inside `ds1302_basemod`.
- After reset it initialises the DS1302: clears write-protect, loads a default time and starts the oscillator.
- It then polls seconds, minutes and hours forever, publishing a BCD time word.
- A host-side set request rewrites the time at the next loop boundary.
- It drives the function module's call/address/data handshake and consumes its done pulse and read byte.

## Interface
Parameters:
- `POLL_CYCLES`, 2_500_000: idle cycles between poll rounds (50 ms at 50 MHz).
- `INIT_TIME`, 24'h12_00_00: BCD {hh,mm,ss} written at power-up.

Ports:
- `CLOCK` in 1: single system clock.
- `RESET` in 1: asynchronous, active-low reset.
- `oCall` out 2: to funcmod; [1]=write, [0]=read, never both set.
- `iDone` in 1: from funcmod; one-cycle pulse when the transaction completes.
- `oAddr` out 8: DS1302 command byte.
- `oData` out 8: write data byte.
- `iData` in 8: byte read back by funcmod, valid when `iDone` is high on a read.
- `iSet` in 1: one-cycle request to set the time.
- `iSetTime` in 24: BCD {hh,mm,ss}, sampled when `iSet`=1.
- `oTime` out 24: last polled BCD {hh,mm,ss}.
- `oTimeValid` out 1: one-cycle pulse when `oTime` updates.
- `oSetAck` out 1: one-cycle pulse when a set sequence completes.

## Operation
- Command bytes:
  - WP write 0x8E; data 0x00.
  - Write hours/min/sec: 0x84 / 0x82 / 0x80.
  - Read hours/min/sec: 0x85 / 0x83 / 0x81.
- States:
  - Init: INIT_WP → INIT_H → INIT_M → INIT_S.
  - Poll: LOOP → RD_S → RD_M → RD_H → PUBLISH → WAIT → LOOP.
  - Set: SET_WP → SET_H → SET_M → SET_S → (oSetAck) LOOP.
- Transaction state behaviour:
  - Drive `oAddr`/`oData` and assert the one `oCall` bit.
  - Hold all three stable until `iDone`.
  - On the cycle `iDone`=1: clear `oCall`, capture `iData` on a read, then advance.
- At least one cycle with `oCall`=00 separates consecutive transactions.
- Write data formatting:
  - Seconds byte bit7 (CH) is forced to 0, which starts the oscillator.
  - Hours byte bit7 is forced to 0 (24 h mode).
- Read data masking: seconds &0x7F, minutes &0x7F, hours &0x3F.
- PUBLISH: `oTime` = {hh,mm,ss} from the three captured bytes; `oTimeValid` pulses.
- WAIT: counts `POLL_CYCLES` cycles, then goes to LOOP.
- LOOP: if a set is pending, go to SET_WP; otherwise go to RD_S.
- Set request handling:
  - `iSet` latches `iSetTime` into a pending register and sets a pending flag in any state.
  - A later `iSet` before service overwrites the value; only one sequence runs, with the newest value.
  - `iSet` in the same cycle that LOOP examines the flag is serviced in that pass.
  - The pending flag clears on entry to SET_WP.
  - `iSet` during init is serviced after INIT_S, before the first read.
  - `iSet` during WAIT takes effect when WAIT expires; WAIT is not aborted.
- BCD validity of `iSetTime` is not checked.

## Timing
- Reset values:
  - Outputs: `oCall`=00, `oAddr`=00, `oData`=00, `oTime`=000000, `oTimeValid`=0, `oSetAck`=0.
  - Internals: state=INIT_WP, pending=0, poll counter=0.
- First transaction: `oCall` asserts on the first clock after reset release.
- Transaction length: set by funcmod, about 16 bits × 25 cycles plus about 5 cycles overhead.
- Idle-to-idle latency of one round is about 3 transactions + 2 cycles.
- `oTimeValid` is asserted exactly one cycle, in the cycle after `iDone` of RD_H.
- `oSetAck` is asserted the cycle after `iDone` of SET_S.
- Reset asserted mid-transaction: everything returns to reset values immediately, and init restarts. funcmod shares `RESET`, so both sides resynchronise.
- `iDone` arriving in a non-transaction state is ignored.

## Structure
- Shared `ds1302_defs` header, also used by funcmod and its testbench, holds:
  - command-byte constants (0x80..0x85, 0x8E);
  - the CH and 12/24 bit masks;
  - the state encodings.
- The poll timer is an inline counter; no sub-module is needed.
- `ds1302_basemod` instantiates `ds1302_ctrlmod` and `ds1302_funcmod` side by side.

## Test plan
- **Reset then release, funcmod stub answering `iDone` after 400 cycles:** call sequence is W(8E,00), W(84,12), W(82,00), W(80,00), then R(81), R(83), R(85).
- **Stub returns 0xA5, 0x59, 0xD3 for sec/min/hr:** `oTime`=13_59_25 and `oTimeValid` high for one cycle.
- **`iSet` with 23_45_C7 during WAIT:** after WAIT, writes W(8E,00), W(84,23), W(82,45), W(80,47), then `oSetAck` pulse, then the reads resume.
- **Two `iSet`s (01_02_03 then 04_05_06) in one poll round:** only the 04_05_06 write sequence occurs.
- **`RESET` pulsed low during RD_M:** `oCall`=00 and `oTime`=0 immediately; INIT_WP restarts after release.
- **DS1302 behavioural model with real funcmod:** `oTime` seconds field increments by 1 per modelled second and wraps 59→00 with a minute increment.
